btn_enable_ctrl: RTL and testbench

Push-button front end that produces the `enable` level for the blinking-light FSM directly downstream. It synchronises a raw mechanical button and debounces both edges. Each accepted press toggles `enable_o`, so one button starts and stops the blinker. An optional long-press feature forces the blinker off.

---
 rtl/btn_enable_ctrl.sv | 132 +++++++++++++
 tb/tb_btn_enable_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_enable_ctrl.sv
// btn_enable_ctrl: push-button front end for the blinker.
// Synchronises and debounces a raw button. Each accepted press toggles enable_o.
// Optional long-press (define BTN_LONG_PRESS_EN): holding the button for
// LONG_CYCLES in PRESSED forces enable_o low and pulses long_o once per hold.
//
// state        | meaning
// IDLE         | button released and debounced, waiting for a press
// PRESS_WAIT   | btn_s high, counting stable cycles before accepting the press
// PRESSED      | press accepted; with long-press enabled, counting hold time
// RELEASE_WAIT | btn_s low, counting stable cycles before accepting the release
module btn_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic enable_o,
  output logic press_o,
  output logic long_o
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_TC  = CW'(LONG_CYCLES - 1);
  // One past the fire compare, so a held button cannot fire a second time.
  localparam logic [CW-1:0] LONG_SAT = CW'(LONG_CYCLES);
`endif

  typedef enum logic [3:0] {
    IDLE         = 4'b0001,
    PRESS_WAIT   = 4'b0010,
    PRESSED      = 4'b0100,
    RELEASE_WAIT = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, btn_s;
  logic          enable_q, enable_d;
  logic          press_q, press_d;
  logic          long_q, long_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1_q  <= btn_i;
      btn_s <= s1_q;
    end
  end

  // State, shared counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      press_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      press_q  <= press_d;
      long_q   <= long_d;
    end
  end

  // Next-state, counter and output decisions; counter clears on any state change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enable_d = enable_q;
    press_d  = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_TC) begin
          state_d  = PRESSED;
          enable_d = ~enable_q;
          press_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
        end
`ifdef BTN_LONG_PRESS_EN
        else if (cnt_q == LONG_TC) begin
          enable_d = 1'b0;
          long_d   = 1'b1;
          cnt_d    = LONG_SAT;
        end else if (cnt_q != LONG_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_TC) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign enable_o = enable_q;
  assign press_o  = press_q;
  assign long_o   = long_q;

endmodule

// File: tb/tb_btn_enable_ctrl.sv
// Testbench for btn_enable_ctrl: directed scenarios plus random button
// activity, compared every cycle against a run-length reference model.
module tb_btn_enable_ctrl;

  localparam int DEB = 4;
  localparam int LNG = 16;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic btn_i  = 1'b0;
  logic enable_o, press_o, long_o;

  int n_checks = 0;
  int n_fail   = 0;

  btn_enable_ctrl #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_i    (btn_i),
    .enable_o (enable_o),
    .press_o  (press_o),
    .long_o   (long_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the button level seen by the controller is btn_i two
  // edges old. A level change is accepted after DEB+1 consecutive samples of
  // the opposite value; an accepted rise toggles enable and pulses press.
  logic m_h0, m_h1, m_x, m_lvl, m_en, m_press, m_long;
  int   m_run, m_hold;
  bit   m_fired;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_h0 = 0; m_h1 = 0; m_lvl = 0; m_en = 0; m_press = 0; m_long = 0;
      m_run = 0; m_hold = 0; m_fired = 0;
    end else begin
      m_x = m_h1;
      m_press = 0;
      m_long  = 0;
      if (m_x != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = m_x;
          m_run = 0;
          if (m_x) begin
            m_en = ~m_en;
            m_press = 1;
            m_hold = 0;
            m_fired = 0;
          end
        end
      end else begin
`ifdef BTN_LONG_PRESS_EN
        if (m_lvl) begin
          if (m_run > 0) begin
            m_hold = 0;
            m_fired = 0;
          end else if (!m_fired) begin
            m_hold++;
            if (m_hold == LNG) begin
              m_en = 0;
              m_long = 1;
              m_fired = 1;
            end
          end
        end
`endif
        m_run = 0;
      end
      m_h1 = m_h0;
      m_h0 = btn_i;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    check_eq("enable", enable_o, m_en);
    check_eq("press",  press_o,  m_press);
    check_eq("long",   long_o,   m_long);
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      btn_i = v;
    end
  endtask

  // Raise the button and return the edge index (0 = first high sample) at
  // which press_o is seen; -1 if it never appears within the budget.
  task automatic press_measure(output int lat);
    @(negedge clk_i);
    btn_i = 1'b1;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_i);
      #1;
      if (press_o) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, pk, lk, nl, en_at_press;
  logic rv;
  int   rn;

  initial begin
    rst_ni = 1'b0;
    btn_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    check_eq("rst_enable", enable_o, 0);
    check_eq("rst_press",  press_o,  0);
    check_eq("rst_long",   long_o,   0);
    drive(0, 20);

    // Clean press and second press.
    press_measure(lat);
    check_eq("press1_latency", lat, DEB + 2);
    check_eq("press1_enable", enable_o, 1);
    drive(1, 4);
    drive(0, 12);
    press_measure(lat);
    check_eq("press2_latency", lat, DEB + 2);
    check_eq("press2_enable", enable_o, 0);
    drive(1, 4);
    drive(0, 12);

    // Bounce pattern must not toggle; a stable press toggles once.
    drive(1, 1); drive(0, 1); drive(1, 1); drive(1, 1); drive(0, 1);
    drive(0, 20);
    check_eq("bounce_enable", enable_o, 0);
    press_measure(lat);
    check_eq("bounce_then_press", lat, DEB + 2);
    drive(1, 4);

    // Release bounce while pressed: no extra press, enable holds.
    drive(0, 2);
    drive(1, 3);
    drive(0, 12);
    check_eq("release_bounce_enable", enable_o, 1);

    // Reset during PRESS_WAIT with enable high.
    drive(1, 4);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("midreset_enable", enable_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_i);
      #1;
      if (enable_o) begin
        lat = k;
        break;
      end
    end
    check_eq("midreset_latency", lat, DEB + 2);
    drive(0, 12);

`ifdef BTN_LONG_PRESS_EN
    // enable is 1 here; one press brings it to 0, then a long hold.
    drive(1, 10);
    drive(0, 12);
    check_eq("long_pre_enable", enable_o, 0);
    @(negedge clk_i);
    btn_i = 1'b1;
    pk = -1; lk = -1; nl = 0; en_at_press = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i);
      #1;
      if (press_o) begin
        pk = k;
        en_at_press = enable_o;
      end
      if (long_o) begin
        nl++;
        lk = k;
      end
    end
    check_eq("long_en_at_press", en_at_press, 1);
    check_eq("long_delay", lk - pk, LNG);
    check_eq("long_pulses", nl, 1);
    check_eq("long_enable_after", enable_o, 0);
    drive(0, 12);
`endif

    // Random activity with a mix of glitches, presses and long holds.
    for (int i = 0; i < 120; i++) begin
      rv = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 12));
      drive(rv, rn);
    end
    drive(0, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
